// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage core: E-stage forwarding,
// load-use stall stretching, redirect flushes and event counters.
module hazard_unit #(
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  resultSrcE,
  input  logic [1:0]  PCSrcE,
  input  logic [4:0]  RdM,
  input  logic        regWriteM,
  input  logic [4:0]  RdW,
  input  logic        regWriteW,
  input  logic        cnt_clr,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  remain_q, remain_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        lwHaz;
  logic        redir;
  logic        stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (regWriteM && RdM == rs && RdM != 5'd0)
      sel = 2'b10;
    else if (regWriteW && RdW == rs && RdW != 5'd0)
      sel = 2'b01;
    return sel;
  endfunction

  assign forwardAE = fwd_sel(Rs1E);
  assign forwardBE = fwd_sel(Rs2E);

  assign lwHaz = (resultSrcE == 2'b01) && (RdE != 5'd0)
              && (RdE == Rs1D || RdE == Rs2D);
  assign redir = (PCSrcE != 2'b00);

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    stall    = 1'b0;
    flushD   = 1'b0;
    flushE   = 1'b0;
    if (redir) begin
      flushD   = 1'b1;
      flushE   = 1'b1;
      state_d  = IDLE;
      remain_d = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lwHaz) begin
            stall  = 1'b1;
            flushE = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d  = STALL;
              remain_d = 3'(LOAD_STALL_CYCLES - 1);
            end
          end
        end
        STALL: begin
          stall  = 1'b1;
          flushE = 1'b1;
          if (remain_q <= 3'd1) begin
            state_d  = IDLE;
            remain_d = 3'd0;
          end else begin
            remain_d = remain_q - 3'd1;
          end
        end
        default: begin
          state_d  = IDLE;
          remain_d = 3'd0;
        end
      endcase
    end
  end

  assign stallF = stall;
  assign stallD = stall;

  // Clear wins over increment; increments wrap naturally at 32 bits.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = 32'd0;
      flush_cnt_d = 32'd0;
    end else begin
      if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
      if (redir) flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remain_q    <= 3'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one default instance and one
// with a 3-cycle load-use stall, both driven by the same stimulus.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  resultSrcE, PCSrcE;
  logic        regWriteM, regWriteW, cnt_clr;

  logic [1:0]  fa1, fb1, fa3, fb3;
  logic        sF1, sD1, fD1, fE1;
  logic        sF3, sD3, fD3, fE3;
  logic [31:0] sc1, fc1, sc3, fc3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit #(.LOAD_STALL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .resultSrcE(resultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .regWriteM(regWriteM),
    .RdW(RdW), .regWriteW(regWriteW), .cnt_clr(cnt_clr),
    .forwardAE(fa1), .forwardBE(fb1),
    .stallF(sF1), .stallD(sD1), .flushD(fD1), .flushE(fE1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_unit #(.LOAD_STALL_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .resultSrcE(resultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .regWriteM(regWriteM),
    .RdW(RdW), .regWriteW(regWriteW), .cnt_clr(cnt_clr),
    .forwardAE(fa3), .forwardBE(fb3),
    .stallF(sF3), .stallD(sD3), .flushD(fD3), .flushE(fE3),
    .stall_cnt(sc3), .flush_cnt(fc3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr_in();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
    RdM = 0; RdW = 0; resultSrcE = 0; PCSrcE = 0;
    regWriteM = 0; regWriteW = 0; cnt_clr = 0;
  endtask

  task automatic set_lw();
    resultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    #2;
    chk("rst_stallF", {31'd0, sF1}, 0);
    chk("rst_stallD3", {31'd0, sD3}, 0);
    chk("rst_flushD", {31'd0, fD1}, 0);
    chk("rst_flushE", {31'd0, fE3}, 0);
    chk("rst_fwdA", {30'd0, fa1}, 0);
    chk("rst_scnt", sc3, 0);
    chk("rst_fcnt", fc3, 0);
    step();
    rst = 1'b0;

    step();
    regWriteM = 1; RdM = 5; regWriteW = 1; RdW = 5;
    Rs1E = 5; Rs2E = 9;
    #1;
    chk("fwd_M_prio", {30'd0, fa1}, 32'h2);
    chk("fwd_B_none", {30'd0, fb1}, 32'h0);
    regWriteM = 0;
    #1;
    chk("fwd_W", {30'd0, fa1}, 32'h1);
    regWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0;
    #1;
    chk("fwd_x0", {30'd0, fa1}, 32'h0);
    RdM = 9; RdW = 5; Rs1E = 5;
    #1;
    chk("fwd_split_B", {30'd0, fb3}, 32'h2);
    chk("fwd_split_A", {30'd0, fa3}, 32'h1);
    clr_in();

    step();
    resultSrcE = 2'b01; RdE = 0; Rs1D = 0;
    #1;
    chk("lw_x0_nostall", {31'd0, sD1}, 0);
    clr_in();

    step();
    set_lw();
    #1;
    chk("lw1_stallF", {31'd0, sF1}, 1);
    chk("lw1_stallD", {31'd0, sD1}, 1);
    chk("lw1_flushE", {31'd0, fE1}, 1);
    chk("lw1_flushD", {31'd0, fD1}, 0);
    chk("lw3_c0", {31'd0, sD3}, 1);
    step();
    clr_in();
    #1;
    chk("lw1_end", {31'd0, sD1}, 0);
    chk("lw3_c1", {31'd0, sD3}, 1);
    chk("lw1_cnt", sc1, 1);
    step();
    #1;
    chk("lw3_c2", {31'd0, sD3}, 1);
    chk("lw3_c2_fE", {31'd0, fE3}, 1);
    step();
    #1;
    chk("lw3_end", {31'd0, sD3}, 0);
    chk("lw3_cnt", sc3, 3);

    step();
    set_lw();
    step();
    clr_in();
    PCSrcE = 2'b01;
    #1;
    chk("redir_flushD", {31'd0, fD3}, 1);
    chk("redir_flushE", {31'd0, fE3}, 1);
    chk("redir_stallD", {31'd0, sD3}, 0);
    chk("redir_stallF", {31'd0, sF3}, 0);
    step();
    clr_in();
    #1;
    chk("redir_idle", {31'd0, sD3}, 0);
    chk("redir_fcnt", fc3, 1);
    chk("redir_scnt3", sc3, 4);
    chk("redir_scnt1", sc1, 2);

    step();
    set_lw();
    step();
    clr_in();
    #1;
    chk("ar_pre", {31'd0, sD3}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_stallD", {31'd0, sD3}, 0);
    chk("ar_stallF", {31'd0, sF3}, 0);
    chk("ar_flushE", {31'd0, fE3}, 0);
    chk("ar_scnt", sc3, 0);
    rst = 1'b0;
    step();
    #1;
    chk("ar_post", {31'd0, sD3}, 0);

    step();
    force dut1.flush_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut1.flush_cnt_q;
    #1;
    chk("wrap_pre", fc1, 32'hFFFF_FFFF);
    PCSrcE = 2'b01;
    step();
    clr_in();
    #1;
    chk("wrap_zero", fc1, 32'h0);
    chk("wrap_fc3", fc3, 32'h1);
    step();
    PCSrcE = 2'b10;
    cnt_clr = 1'b1;
    #1;
    chk("clr_flushD", {31'd0, fD3}, 1);
    step();
    clr_in();
    #1;
    chk("clr_fc3", fc3, 0);
    chk("clr_fc1", fc1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
